// File: rtl/pacman_move_ctrl_pkg.sv
// Shared definitions for the Pac-Man movement controller.
// Holds the direction encodings, the controller FSM state encoding, the sprite
// size and the default screen limits (160x120 frame buffer).
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERASE = 3'd1,
        ST_MOVE  = 3'd2,
        ST_DRAW  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    localparam int         SPRITE_SIZE  = 5;
    localparam logic [2:0] SPRITE_LAST  = 3'(SPRITE_SIZE - 1);
    localparam logic [7:0] SCREEN_X_MAX = 8'd159;
    localparam logic [6:0] SCREEN_Y_MAX = 7'd119;

endpackage

// File: rtl/pacman_move_ctrl_if.sv
// Signal bundle between the movement controller and its surroundings.
//   enable/dir_req/dir_valid : game control inputs
//   done_print, draw_*       : sprite drawer handshake and pixel stream in
//   draw_en/startx/starty/sprite_sel : sprite drawer control out
//   vga_*                    : pixel stream to the frame buffer
//   busy/frame_done          : status
// slave = controller view, master = environment (game logic / bench) view.
interface pacman_move_ctrl_if;
    logic       enable;
    logic [1:0] dir_req;
    logic       dir_valid;
    logic       done_print;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic       draw_colour;
    logic       draw_en;
    logic [7:0] startx;
    logic [6:0] starty;
    logic [1:0] sprite_sel;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic       vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       frame_done;

    modport slave (
        input  enable, dir_req, dir_valid, done_print, draw_x, draw_y, draw_colour,
        output draw_en, startx, starty, sprite_sel,
        output vga_x, vga_y, vga_colour, vga_plot, busy, frame_done
    );

    modport master (
        output enable, dir_req, dir_valid, done_print, draw_x, draw_y, draw_colour,
        input  draw_en, startx, starty, sprite_sel,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, frame_done
    );
endinterface

// File: rtl/pacman_move_ctrl_sprite_erase.sv
// 5x5 black-fill scanner.
//   clock, reset : clock and synchronous active-high reset
//   start        : held high for the whole scan; low clears the scan position
//   org_x/org_y  : sprite top-left corner
//   pix_x/pix_y  : current pixel (column advances fastest), plot while start
//   done         : high on the last pixel (4,4)
module sprite_erase
    import pacman_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] org_x,
    input  logic [6:0] org_y,
    output logic [7:0] pix_x,
    output logic [6:0] pix_y,
    output logic       plot,
    output logic       done
);
    logic [2:0] ex_reg;
    logic [2:0] ey_reg;

    always_ff @(posedge clock) begin
        if (reset || !start) begin
            ex_reg <= 3'd0;
            ey_reg <= 3'd0;
        end else if (ex_reg == SPRITE_LAST) begin
            ex_reg <= 3'd0;
            ey_reg <= (ey_reg == SPRITE_LAST) ? 3'd0 : ey_reg + 3'd1;
        end else begin
            ex_reg <= ex_reg + 3'd1;
        end
    end

    // Origin is clamped by the controller, so these sums never exceed 159/119.
    assign pix_x = org_x + {5'd0, ex_reg};
    assign pix_y = org_y + {4'd0, ey_reg};
    assign plot  = start;
    assign done  = start && (ex_reg == SPRITE_LAST) && (ey_reg == SPRITE_LAST);
endmodule

// File: rtl/pacman_move_ctrl.sv
// Pac-Man movement controller: each frame erases the 5x5 sprite, steps the
// position one pixel in the latched direction (clamped to the screen), hands
// the sprite drawer the new origin, then idles FRAME_TICKS cycles.
//   clock, reset : clock and synchronous active-high reset
//   bus          : controller side of pacman_move_ctrl_if (see that file)
module pacman_move_ctrl
    import pacman_pkg::*;
#(
    parameter logic [7:0]  START_X     = 8'd10,
    parameter logic [6:0]  START_Y     = 7'd10,
    parameter logic [23:0] FRAME_TICKS = 24'd833333,
    parameter logic [7:0]  X_MAX       = SCREEN_X_MAX,
    parameter logic [6:0]  Y_MAX       = SCREEN_Y_MAX
) (
    input  logic                clock,
    input  logic                reset,
    pacman_move_ctrl_if.slave   bus
);
    // Highest legal top-left corner so the whole sprite stays on screen.
    localparam logic [7:0] X_LIM = X_MAX - 8'(SPRITE_SIZE - 1);
    localparam logic [6:0] Y_LIM = Y_MAX - 7'(SPRITE_SIZE - 1);

    state_t      state_reg, state_next;
    logic [7:0]  pos_x_reg, pos_x_next;
    logic [6:0]  pos_y_reg, pos_y_next;
    dir_t        dir_latched_reg, dir_latched_next;
    logic        moving_reg, moving_next;
    dir_t        sprite_sel_reg, sprite_sel_next;
    logic [23:0] wait_cnt_reg, wait_cnt_next;

    logic        erase_run;
    logic [7:0]  erase_x;
    logic [6:0]  erase_y;
    logic        erase_plot;
    logic        erase_done;

    assign erase_run = (state_reg == ST_ERASE);

    sprite_erase u_erase (
        .clock (clock),
        .reset (reset),
        .start (erase_run),
        .org_x (pos_x_reg),
        .org_y (pos_y_reg),
        .pix_x (erase_x),
        .pix_y (erase_y),
        .plot  (erase_plot),
        .done  (erase_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            pos_x_reg       <= START_X;
            pos_y_reg       <= START_Y;
            dir_latched_reg <= DIR_RIGHT;
            moving_reg      <= 1'b0;
            sprite_sel_reg  <= DIR_RIGHT;
            wait_cnt_reg    <= 24'd0;
        end else begin
            state_reg       <= state_next;
            pos_x_reg       <= pos_x_next;
            pos_y_reg       <= pos_y_next;
            dir_latched_reg <= dir_latched_next;
            moving_reg      <= moving_next;
            sprite_sel_reg  <= sprite_sel_next;
            wait_cnt_reg    <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pos_x_next      = pos_x_reg;
        pos_y_next      = pos_y_reg;
        sprite_sel_next = sprite_sel_reg;
        wait_cnt_next   = wait_cnt_reg;
        // A request is captured in any state; MOVE reads the registered copy,
        // so a request arriving during MOVE only affects the next frame.
        dir_latched_next = bus.dir_valid ? dir_t'(bus.dir_req) : dir_latched_reg;
        moving_next      = moving_reg | bus.dir_valid;

        bus.vga_x      = pos_x_reg;
        bus.vga_y      = pos_y_reg;
        bus.vga_colour = 1'b0;
        bus.vga_plot   = 1'b0;
        bus.draw_en    = 1'b0;
        bus.frame_done = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.enable) state_next = ST_ERASE;
            end
            ST_ERASE: begin
                bus.vga_x    = erase_x;
                bus.vga_y    = erase_y;
                bus.vga_plot = erase_plot;
                if (erase_done) state_next = ST_MOVE;
            end
            ST_MOVE: begin
                sprite_sel_next = dir_latched_reg;
                if (moving_reg) begin
                    // A step that would leave the screen is simply dropped.
                    case (dir_latched_reg)
                        DIR_UP:    if (pos_y_reg != 7'd0)  pos_y_next = pos_y_reg - 7'd1;
                        DIR_DOWN:  if (pos_y_reg < Y_LIM)  pos_y_next = pos_y_reg + 7'd1;
                        DIR_LEFT:  if (pos_x_reg != 8'd0)  pos_x_next = pos_x_reg - 8'd1;
                        DIR_RIGHT: if (pos_x_reg < X_LIM)  pos_x_next = pos_x_reg + 8'd1;
                        default: ;
                    endcase
                end
                state_next = ST_DRAW;
            end
            ST_DRAW: begin
                bus.draw_en    = 1'b1;
                bus.vga_x      = bus.draw_x;
                bus.vga_y      = bus.draw_y;
                bus.vga_colour = bus.draw_colour;
                bus.vga_plot   = 1'b1;
                if (bus.done_print) begin
                    wait_cnt_next = FRAME_TICKS - 24'd1;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == 24'd0) begin
                    bus.frame_done = 1'b1;
                    state_next     = bus.enable ? ST_ERASE : ST_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 24'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.startx     = pos_x_reg;
    assign bus.starty     = pos_y_reg;
    assign bus.sprite_sel = sprite_sel_reg;
endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl with FRAME_TICKS=4. Each frame is
// walked cycle by cycle against hand-computed pixel, origin and timing values.
module tb_pacman_move_ctrl;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   frame_no;
    logic [7:0] cx, nx;
    logic [6:0] cy, ny;

    pacman_move_ctrl_if bus ();

    pacman_move_ctrl #(
        .FRAME_TICKS (24'd4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the first ERASE cycle; returns at the first cycle after WAIT
    // (or one cycle after reset when rst_draw is set).
    task automatic do_frame(input logic [7:0] ox, input logic [6:0] oy,
                            input logic [7:0] ex_nx, input logic [6:0] ex_ny,
                            input logic [1:0] ex_sel,
                            input bit pre_v, input logic [1:0] pre_d,
                            input bit mv_v, input logic [1:0] mv_d,
                            input bit drop_en, input bit rst_draw);
        logic [7:0] px;
        logic [6:0] py;
        for (int ey = 0; ey < 5; ey++) begin
            for (int ex = 0; ex < 5; ex++) begin
                if (ey == 0 && ex == 0) begin
                    if (pre_v) begin
                        bus.dir_valid = 1'b1;
                        bus.dir_req   = pre_d;
                    end
                    if (drop_en) bus.enable = 1'b0;
                end else begin
                    bus.dir_valid = 1'b0;
                end
                px = ox + 8'(ex);
                py = oy + 7'(ey);
                check_val("erase_pixel", {15'd0, bus.vga_plot, bus.vga_colour, bus.vga_x, bus.vga_y},
                          {15'd0, 1'b1, 1'b0, px, py});
                tick();
            end
        end
        bus.dir_valid = 1'b0;
        check_val("move_outputs", {29'd0, bus.vga_plot, bus.draw_en, bus.busy}, 32'd1);
        if (mv_v) begin
            bus.dir_valid = 1'b1;
            bus.dir_req   = mv_d;
        end
        tick();
        bus.dir_valid = 1'b0;
        check_val("draw_origin", {13'd0, bus.draw_en, bus.sprite_sel, bus.startx, bus.starty},
                  {13'd0, 1'b1, ex_sel, ex_nx, ex_ny});
        if (rst_draw) begin
            reset = 1'b1;
            tick();
            check_val("rst_outputs", {29'd0, bus.busy, bus.draw_en, bus.vga_plot}, 32'd0);
            check_val("rst_pos", {15'd0, bus.sprite_sel, bus.startx, bus.starty},
                      {15'd0, 2'b11, 8'd10, 7'd10});
            reset = 1'b0;
            $display("frame %0d: reset in DRAW at (%0d,%0d)", frame_no, ex_nx, ex_ny);
            frame_no++;
            return;
        end
        bus.draw_x      = ex_nx + 8'd1;
        bus.draw_y      = ex_ny + 7'd2;
        bus.draw_colour = 1'b1;
        #1;
        check_val("draw_passthru", {15'd0, bus.vga_plot, bus.vga_colour, bus.vga_x, bus.vga_y},
                  {15'd0, 1'b1, 1'b1, ex_nx + 8'd1, ex_ny + 7'd2});
        tick();
        check_val("draw_en_held", {31'd0, bus.draw_en}, 32'd1);
        bus.done_print = 1'b1;
        tick();
        bus.done_print  = 1'b0;
        bus.draw_colour = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("wait_outputs", {28'd0, bus.busy, bus.vga_plot, bus.draw_en, bus.frame_done},
                      {28'd0, 1'b1, 1'b0, 1'b0, (i == 3)});
            tick();
        end
        $display("frame %0d: erase (%0d,%0d) -> pos (%0d,%0d) sel %0d", frame_no, ox, oy, ex_nx, ex_ny, ex_sel);
        frame_no++;
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        frame_no        = 0;
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.dir_req     = 2'b00;
        bus.dir_valid   = 1'b0;
        bus.done_print  = 1'b0;
        bus.draw_x      = 8'd0;
        bus.draw_y      = 7'd0;
        bus.draw_colour = 1'b0;
        repeat (3) tick();

        // Reset values
        check_val("rst_status", {27'd0, bus.busy, bus.draw_en, bus.vga_plot, bus.vga_colour, bus.frame_done}, 32'd0);
        check_val("rst_vga_xy", {17'd0, bus.vga_x, bus.vga_y}, {17'd0, 8'd10, 7'd10});
        check_val("rst_origin", {15'd0, bus.sprite_sel, bus.startx, bus.starty}, {15'd0, 2'b11, 8'd10, 7'd10});
        reset = 1'b0;
        tick();
        check_val("idle_busy", {31'd0, bus.busy}, 32'd0);

        // Frame with no direction, enable dropped in first ERASE cycle.
        bus.enable = 1'b1;
        tick();
        do_frame(8'd10, 7'd10, 8'd10, 7'd10, 2'b11, 0, 2'b00, 0, 2'b00, 1, 0);
        check_val("idle_after_drop", {28'd0, bus.busy, bus.draw_en, bus.vga_plot, bus.frame_done}, 32'd0);

        // Direction request while idle: right.
        bus.dir_valid = 1'b1;
        bus.dir_req   = 2'b11;
        tick();
        bus.dir_valid = 1'b0;
        check_val("idle_hold", {31'd0, bus.busy}, 32'd0);
        bus.enable = 1'b1;
        tick();
        do_frame(8'd10, 7'd10, 8'd11, 7'd10, 2'b11, 0, 2'b00, 0, 2'b00, 0, 0);
        do_frame(8'd11, 7'd10, 8'd12, 7'd10, 2'b11, 0, 2'b00, 0, 2'b00, 0, 0);

        // Latch down early, request up in the MOVE cycle itself.
        do_frame(8'd12, 7'd10, 8'd12, 7'd11, 2'b01, 1, 2'b01, 1, 2'b00, 0, 0);
        do_frame(8'd12, 7'd11, 8'd12, 7'd10, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0);

        // Keep moving up until clamped at row 0.
        cx = 8'd12;
        cy = 7'd10;
        for (int k = 0; k < 12; k++) begin
            ny = (cy == 7'd0) ? 7'd0 : cy - 7'd1;
            do_frame(cx, cy, cx, ny, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0);
            cy = ny;
        end
        check_val("y_clamped", {25'd0, bus.starty}, 32'd0);

        // Turn right and run into the right edge (last legal x = 155).
        for (int k = 0; k < 145; k++) begin
            nx = (cx >= 8'd155) ? 8'd155 : cx + 8'd1;
            do_frame(cx, cy, nx, cy, 2'b11, (k == 0), 2'b11, 0, 2'b00, 0, 0);
            cx = nx;
        end
        check_val("x_clamped", {24'd0, bus.startx}, 32'd155);

        // Reset while the drawer is active.
        do_frame(cx, cy, cx, cy, 2'b11, 0, 2'b00, 0, 2'b00, 1, 1);
        tick();
        check_val("idle_after_rst", {29'd0, bus.busy, bus.draw_en, bus.vga_plot}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pacman_move_ctrl.md
PACMAN_MOVE_CTRL -- requirements
Module: pacman_move_ctrl

Interface
REQ-001 SHALL have parameter START_X, default 8'd10, reset x position of sprite top-left corner.
REQ-002 SHALL have parameter START_Y, default 7'd10, reset y position of sprite top-left corner.
REQ-003 SHALL have parameter FRAME_TICKS, default 24'd833333, clock cycles spent in WAIT per frame (minimum 1).
REQ-004 SHALL have parameter X_MAX, default 8'd159, and Y_MAX, default 7'd119, the last visible screen column and row.
REQ-005 Ports: clock  in  1  sole clock, all logic on rising edge.
REQ-006 Ports: reset  in  1  synchronous, active-high.
REQ-007 Ports: enable  in  1  game running; dir_req  in  2  requested direction (00 up, 01 down, 10 left, 11 right); dir_valid  in  1  dir_req qualifier.
REQ-008 Ports: done_print  in  1  from sprite drawer; draw_x  in  8, draw_y  in  7, draw_colour  in  1  drawer pixel stream.
REQ-009 Ports: draw_en  out  1  drawer writeEn; startx  out  8, starty  out  7  drawer origin; sprite_sel  out  2  selects direction sprite.
REQ-010 Ports: vga_x  out  8, vga_y  out  7, vga_colour  out  1, vga_plot  out  1  pixel stream to frame buffer.
REQ-011 Ports: busy  out  1  high in any state but IDLE; frame_done  out  1  one-cycle pulse at end of each frame.

Function
REQ-012 SHALL implement FSM states IDLE, ERASE, MOVE, DRAW, WAIT.
REQ-013 IDLE: all enables low; enable=1 -> ERASE next cycle.
REQ-014 ERASE: exactly 25 cycles scanning ex,ey 0..4 (ex fastest); vga_plot=1, vga_x=pos_x+ex, vga_y=pos_y+ey, vga_colour=0; after (ex=4,ey=4) -> MOVE.
REQ-015 MOVE: one cycle; if moving=1 step pos one pixel in latched direction, clamped so pos_x in [0, X_MAX-4], pos_y in [0, Y_MAX-4]; sprite_sel <= latched direction; vga_plot=0; -> DRAW.
REQ-016 A clamped step SHALL leave the position unchanged (no wrap-around) and still proceed to DRAW.
REQ-017 DRAW: draw_en=1, startx=pos_x, starty=pos_y; vga_x/vga_y/vga_colour pass through draw_x/draw_y/draw_colour combinationally, vga_plot=1.
REQ-018 DRAW: on done_print=1 -> WAIT next cycle, draw_en=0 from that cycle.
REQ-019 WAIT: vga_plot=0; counter loaded FRAME_TICKS-1 on entry, decrements each cycle; at 0 pulse frame_done for one cycle, then -> ERASE if enable=1 else IDLE.
REQ-020 enable is sampled only in IDLE and at WAIT exit; deassertion mid-frame SHALL complete the frame.
REQ-021 dir_valid=1 in any state SHALL latch dir_req into dir_latched and set moving=1; the value latched applies at the next MOVE.
REQ-022 dir_valid in the same cycle as MOVE: MOVE uses the prior dir_latched; the new value applies next frame.
REQ-023 startx/starty SHALL hold pos_x/pos_y in all states; no output arithmetic SHALL overflow given REQ-015 clamps.

Reset
REQ-024 On reset=1: state IDLE, pos_x=START_X, pos_y=START_Y, dir_latched=11, moving=0, sprite_sel=11, counters 0.
REQ-025 On reset=1: draw_en, vga_plot, vga_colour, busy, frame_done = 0; vga_x=START_X, vga_y=START_Y.
REQ-026 Reset mid-ERASE/DRAW/WAIT SHALL abort immediately; no partial frame resumes.

Structure
REQ-027 Shared package pacman_pkg SHALL hold direction encodings, FSM state encoding, SPRITE_SIZE=5, screen limits.
REQ-028 The 5x5 black-fill scanner SHALL be one sub-module, sprite_erase (start, x/y origin in, pixel out, done out).

Verification
REQ-029 Reset, enable=1, no dir_valid, FRAME_TICKS=4 -> 25 erase pixels at (10..14,10..14) colour 0, position unchanged, draw_en high until done_print, frame_done pulse after 4 WAIT cycles.
REQ-030 dir_valid with dir_req=11 in IDLE -> after first MOVE pos_x=11, sprite_sel=11; second frame erases at x=11..15.
REQ-031 START_X=155, dir right -> pos_x stays 155 across frames, no wrap, DRAW still occurs.
REQ-032 dir_valid=00 asserted exactly in MOVE cycle while latched=01 -> that frame moves down, next frame moves up.
REQ-033 enable dropped mid-ERASE -> frame completes, frame_done pulses, FSM enters IDLE, busy=0.
REQ-034 reset asserted mid-DRAW -> next cycle IDLE, draw_en=0, vga_plot=0, pos=(START_X,START_Y).
